// File: rtl/shift_exec_pipe.sv
// Two-stage execute wrapper around the external combinational Shift_Unit:
// issue register (A) drives the shifter, result register (B) feeds writeback.
module shift_exec_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [4:0]       in_shamt,
  input  logic             in_use_imm,
  input  logic             in_funct3_2,
  input  logic             in_funct7_5,
  input  logic [TAG_W-1:0] in_rd,
  output logic [XLEN-1:0]  sh_Src1,
  output logic [5:0]       sh_Src2,
  output logic             sh_funct3_2,
  output logic             sh_funct7_5,
  output logic             sh_En,
  input  logic [XLEN-1:0]  sh_Result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_rd
);

  logic             a_valid;
  logic [XLEN-1:0]  a_rs1;
  logic [4:0]       a_shamt;
  logic             a_f3;
  logic             a_f7;
  logic [TAG_W-1:0] a_rd;

  logic             b_valid;
  logic [XLEN-1:0]  b_result;
  logic [TAG_W-1:0] b_rd;

  logic             b_free;
  logic             a_adv;
  logic             accept;
  logic [4:0]       shamt_sel;

  // Only rs2[4:0] carries a shift amount; upper bits are intentionally dropped.
  logic unused_rs2_hi;
  assign unused_rs2_hi = ^in_rs2[XLEN-1:5];

  assign b_free    = !b_valid || out_ready;
  assign a_adv     = a_valid && b_free;
  assign in_ready  = !a_valid || b_free;
  assign accept    = in_valid && in_ready && !flush;
  assign shamt_sel = in_use_imm ? in_shamt : in_rs2[4:0];

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_rs1   <= '0;
      a_shamt <= '0;
      a_f3    <= 1'b0;
      a_f7    <= 1'b0;
      a_rd    <= '0;
    end else begin
      if (flush)
        a_valid <= 1'b0;
      else if (accept)
        a_valid <= 1'b1;
      else if (a_adv)
        a_valid <= 1'b0;
      if (accept) begin
        a_rs1   <= in_rs1;
        a_shamt <= shamt_sel;
        a_f3    <= in_funct3_2;
        a_f7    <= in_funct7_5;
        a_rd    <= in_rd;
      end
    end
  end

  // Flush outranks advance, so a killed op never lands in B.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      b_valid  <= 1'b0;
      b_result <= '0;
      b_rd     <= '0;
    end else begin
      if (flush)
        b_valid <= 1'b0;
      else if (a_adv)
        b_valid <= 1'b1;
      else if (out_ready)
        b_valid <= 1'b0;
      if (a_adv && !flush) begin
        b_result <= sh_Result;
        b_rd     <= a_rd;
      end
    end
  end

  assign sh_Src1     = a_rs1;
  assign sh_Src2     = {1'b0, a_shamt};
  assign sh_funct3_2 = a_f3;
  assign sh_funct7_5 = a_f7;
  assign sh_En       = a_valid;

  assign out_valid  = b_valid;
  assign out_result = b_result;
  assign out_rd     = b_rd;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Directed and randomized checks of shift_exec_pipe with a behavioural
// Shift_Unit attached to its sh_* ports.
module tb_shift_exec_pipe;

  logic        CLK;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_shamt;
  logic        in_use_imm;
  logic        in_funct3_2;
  logic        in_funct7_5;
  logic [4:0]  in_rd;
  logic [31:0] sh_Src1;
  logic [5:0]  sh_Src2;
  logic        sh_funct3_2;
  logic        sh_funct7_5;
  logic        sh_En;
  logic [31:0] sh_Result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  int n_cmp;
  int n_bad;

  shift_exec_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .CLK(CLK), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_shamt(in_shamt),
    .in_use_imm(in_use_imm), .in_funct3_2(in_funct3_2),
    .in_funct7_5(in_funct7_5), .in_rd(in_rd),
    .sh_Src1(sh_Src1), .sh_Src2(sh_Src2),
    .sh_funct3_2(sh_funct3_2), .sh_funct7_5(sh_funct7_5),
    .sh_En(sh_En), .sh_Result(sh_Result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] shf(input logic [31:0] a,
                                      input logic [4:0] s,
                                      input logic f3, input logic f7);
    logic [31:0] r;
    r = 32'h0;
    case ({f7, f3})
      2'b00: r = a << s;
      2'b01: r = a >> s;
      2'b11: r = $unsigned($signed(a) >>> s);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Behavioural Shift_Unit
  always_comb begin
    sh_Result = 32'h0;
    if (sh_En)
      sh_Result = shf(sh_Src1, sh_Src2[4:0], sh_funct3_2, sh_funct7_5);
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_op(input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] sh, input logic imm,
                        input logic f3, input logic f7,
                        input logic [4:0] rd);
    in_valid    = 1'b1;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_shamt    = sh;
    in_use_imm  = imm;
    in_funct3_2 = f3;
    in_funct7_5 = f7;
    in_rd       = rd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++;
    if (out_valid !== 1'b0 || sh_En !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ctrl: ov=%b en=%b ir=%b want 0 0 1",
               out_valid, sh_En, in_ready);
    end
    n_cmp++;
    if (out_result !== 32'h0 || out_rd !== 5'h0 || sh_Src1 !== 32'h0 ||
        sh_Src2 !== 6'h0 || sh_funct3_2 !== 1'b0 || sh_funct7_5 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_data: res=%h rd=%h s1=%h s2=%h want zeros",
               out_result, out_rd, sh_Src1, sh_Src2);
    end
    @(negedge CLK);
    rst = 1'b0;
    step();
  endtask

  task automatic test_sll();
    out_ready = 1'b1;
    set_op(32'd50, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd7);
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (sh_En !== 1'b1 || sh_Src1 !== 32'd50 || sh_Src2 !== 6'd4 ||
        out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sll_issue: en=%b s1=%h s2=%h ov=%b want 1 32 4 0",
               sh_En, sh_Src1, sh_Src2, out_valid);
    end
    step();
    chk("sll_valid", {31'h0, out_valid}, 32'h1);
    chk("sll_result", out_result, 32'd800);
    chk("sll_rd", {27'h0, out_rd}, 32'd7);
    step();
    chk("sll_drain", {31'h0, out_valid}, 32'h0);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    set_op(32'hABCDFFFF, 32'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3);
    step();
    set_op(32'hABCDFFFF, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4);
    step();
    in_valid = 1'b0;
    chk("srl_result", out_result, 32'h055E6FFF);
    chk("srl_rd", {27'h0, out_rd}, 32'd3);
    step();
    chk("sra_valid", {31'h0, out_valid}, 32'h1);
    chk("sra_result", out_result, 32'hF579BFFF);
    chk("sra_rd", {27'h0, out_rd}, 32'd4);
    step();
  endtask

  task automatic test_src_select();
    out_ready = 1'b1;
    set_op(32'd1, 32'hFFFFFFE3, 5'd9, 1'b0, 1'b0, 1'b0, 5'd10);
    step();
    set_op(32'd1, 32'hFFFFFFE3, 5'd9, 1'b1, 1'b0, 1'b0, 5'd11);
    step();
    in_valid = 1'b0;
    chk("src_rs2", out_result, 32'h8);
    step();
    chk("src_imm", out_result, 32'h200);
    step();
  endtask

  task automatic test_not_shift();
    out_ready = 1'b1;
    set_op(32'h12345678, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 5'd12);
    step();
    in_valid = 1'b0;
    step();
    chk("f7f3_10_valid", {31'h0, out_valid}, 32'h1);
    chk("f7f3_10_result", out_result, 32'h0);
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_op(32'd1, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd1);
    #1;
    chk("bp_ready1", {31'h0, in_ready}, 32'h1);
    step();
    set_op(32'd2, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd2);
    #1;
    chk("bp_ready2", {31'h0, in_ready}, 32'h1);
    step();
    set_op(32'd3, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd3);
    #1;
    chk("bp_ready_full", {31'h0, in_ready}, 32'h0);
    step();
    chk("bp_hold_rd", {27'h0, out_rd}, 32'd1);
    chk("bp_hold_res", out_result, 32'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_pop", {31'h0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    chk("bp_tag2", {26'h0, out_valid, out_rd}, {26'h0, 1'b1, 5'd2});
    step();
    chk("bp_tag3", {26'h0, out_valid, out_rd}, {26'h0, 1'b1, 5'd3});
    chk("bp_tag3_res", out_result, 32'd6);
    step();
    chk("bp_empty", {31'h0, out_valid}, 32'h0);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_op(32'd5, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd20);
    step();
    set_op(32'd6, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd21);
    step();
    out_ready = 1'b1;
    flush = 1'b1;
    set_op(32'd7, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd9);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || sh_En !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_kill: ov=%b en=%b want 0 0", out_valid, sh_En);
    end
    for (int i = 0; i < 3; i++) begin
      if (out_valid === 1'b1 && out_rd === 5'd9) begin
        n_bad++;
        $display("FAIL flush_ghost: got rd %h expected none", out_rd);
      end
      step();
    end
    chk("flush_after", {31'h0, out_valid}, 32'h0);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_op(32'd8, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 5'd13);
    step();
    set_op(32'd9, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 5'd14);
    step();
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || sh_En !== 1'b0 || out_result !== 32'h0 ||
        in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid: ov=%b en=%b res=%h ir=%b want 0 0 0 1",
               out_valid, sh_En, out_result, in_ready);
    end
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    set_op(32'd3, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd15);
    step();
    in_valid = 1'b0;
    chk("rst_mid_lat1", {31'h0, out_valid}, 32'h0);
    step();
    chk("rst_mid_res", out_result, 32'd24);
    chk("rst_mid_rd", {26'h0, out_valid, out_rd}, {26'h0, 1'b1, 5'd15});
    step();
    chk("rst_mid_none", {31'h0, out_valid}, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] q_res[$];
    logic [4:0]  q_rd[$];
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  si;
    logic        ui;
    logic        f3;
    logic        f7;
    logic [4:0]  rd;
    int          acc;
    int          cyc;
    acc = 0;
    cyc = 0;
    while ((acc < 1000 || q_res.size() != 0) && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0) || (acc >= 1000);
      r1 = $urandom;
      r2 = $urandom;
      si = 5'($urandom);
      ui = 1'($urandom);
      f3 = 1'($urandom);
      f7 = 1'($urandom);
      rd = 5'($urandom);
      set_op(r1, r2, si, ui, f3, f7, rd);
      in_valid = (acc < 1000) && ($urandom_range(0, 4) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q_res.size() == 0) begin
          n_bad++;
          $display("FAIL rnd_extra: got rd %h expected no output", out_rd);
        end else begin
          if (out_result !== q_res[0] || out_rd !== q_rd[0]) begin
            n_bad++;
            $display("FAIL rnd_data: got %h/%h expected %h/%h",
                     out_result, out_rd, q_res[0], q_rd[0]);
          end
          void'(q_res.pop_front());
          void'(q_rd.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q_res.push_back(shf(r1, ui ? si : r2[4:0], f3, f7));
        q_rd.push_back(rd);
        acc++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (cyc >= 20000 || q_res.size() != 0) begin
      n_bad++;
      $display("FAIL rnd_timeout: got %0d pending expected 0", q_res.size());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_rs1 = '0;
    in_rs2 = '0;
    in_shamt = '0;
    in_use_imm = 1'b0;
    in_funct3_2 = 1'b0;
    in_funct7_5 = 1'b0;
    in_rd = '0;
    #1;
    test_reset();
    test_sll();
    test_back_to_back();
    test_src_select();
    test_not_shift();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
